// File: rtl/tff_count_pkg.sv
// Shared state encoding, direction constants and the wrapped next-value helper
// for the toggle-flop modulo counter.
package tff_count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int CNT_MAX_W = 32;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  // A modulus of 0 stands for 2**WIDTH; callers truncate the result to WIDTH
  // bits, which turns the unmatched compare into the natural binary wrap.
  function automatic cnt_t next_count(input cnt_t cnt, input cnt_t mod, input logic dir);
    cnt_t modM1;
    modM1 = mod - cnt_t'(1);
    if (dir == DIR_UP) begin
      next_count = (cnt == modM1) ? '0 : cnt + cnt_t'(1);
    end else begin
      next_count = (cnt == '0) ? modM1 : cnt - cnt_t'(1);
    end
  endfunction

endpackage

// File: rtl/tff_bit.sv
// Single toggle flip-flop: q inverts on every rising edge where t is high.
module tff_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequences a bank of WIDTH toggle flip-flops as a programmable modulo-N
// up/down counter with config handshake, run/pause control and one-shot mode.
module tff_count_ctrl
  import tff_count_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic             cfg_dir,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] mod_q;
  logic             dir_q;
  logic             oneshot_q;
  logic             done_q;
  logic             reload_q;

  logic             cfgAccept;
  logic             wrap;
  logic [WIDTH-1:0] modM1;
  logic [WIDTH-1:0] initVal;
  logic [WIDTH-1:0] nextVal;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_bit u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .t    (t_vec[i]),
      .q    (count[i])
    );
  end

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign done      = done_q;
  assign cfgAccept = cfg_valid && cfg_ready;

  // A config accept only latches the settings; the bank reloads INIT on the
  // following edge from the stored values, so cfg_* never reaches t_vec.
  always_comb begin
    modM1   = mod_q - WIDTH'(1);
    initVal = (dir_q == DIR_UP) ? '0 : modM1;
    wrap    = (dir_q == DIR_UP) ? (count == modM1) : (count == '0);
    nextVal = WIDTH'(next_count(cnt_t'(count), cnt_t'(mod_q), dir_q));
    tc      = (state_q == RUN) && !stop && wrap;
    t_vec   = '0;
    case (state_q)
      IDLE:  if (reload_q) t_vec = count ^ initVal;
      RUN:   if (!stop) t_vec = count ^ nextVal;
      PAUSE: t_vec = '0;
      DONE:  if (start && !stop) t_vec = count ^ initVal;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mod_q     <= WIDTH'(DEFAULT_MOD);
      dir_q     <= DIR_UP;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
      reload_q  <= 1'b0;
    end else begin
      reload_q <= 1'b0;
      if (cfgAccept) begin
        mod_q     <= cfg_mod;
        dir_q     <= cfg_dir;
        oneshot_q <= cfg_oneshot;
        done_q    <= 1'b0;
        reload_q  <= 1'b1;
        state_q   <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !stop) state_q <= RUN;
          end
          RUN: begin
            if (stop) begin
              state_q <= PAUSE;
            end else if (wrap && oneshot_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          PAUSE: begin
            if (stop) begin
              state_q <= IDLE;
            end else if (start) begin
              state_q <= RUN;
            end
          end
          DONE: begin
            if (start && !stop) begin
              state_q <= RUN;
              done_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule
